button_toggle: RTL and testbench
================================

# button_toggle

Debounced pushbutton front end that turns a raw, bouncing, asynchronous button input into a clean one-cycle `toggle` strobe and a debounced `pressed` level. It sits between a board pushbutton pin and the LED toggle logic, driving that logic's `toggle` input. It synchronises the pin, filters bounce with a cycle counter under a 4-state FSM, and emits exactly one strobe per accepted press, or per accepted release when so configured.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a level change; legal range ≥1.
- `TOGGLE_ON_RELEASE`, default 0: 0 = strobe on accepted press; 1 = strobe on accepted release.
- `clk`  in  1  system clock; all flops rise-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn`  in  1  raw button, active-high, asynchronous to `clk`, may bounce.
- `toggle`  out  1  registered one-cycle strobe per accepted event.
- `pressed`  out  1  registered debounced button level.

## Operation
- Synchroniser:
  - Two flops, `btn` → s1 → s2.
  - Only s2 (`btn_s`) is used downstream.
- Counter:
  - Width max(1, clog2(DEBOUNCE_CYCLES)).
  - Cleared on every state entry.
- FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
- RELEASED:
  - `btn_s`=1 → PRESS_CHK, cnt=0.
- PRESS_CHK:
  - `btn_s`=0 → RELEASED. Bounce; no output change.
  - `btn_s`=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED. Set `pressed`=1 and `toggle`=!TOGGLE_ON_RELEASE.
  - Otherwise cnt+1.
- PRESSED:
  - `btn_s`=0 → RELEASE_CHK, cnt=0.
- RELEASE_CHK:
  - `btn_s`=1 → PRESSED. Glitch; no strobe, `pressed` stays 1.
  - `btn_s`=0 and cnt==DEBOUNCE_CYCLES-1 → RELEASED. Set `pressed`=0 and `toggle`=TOGGLE_ON_RELEASE.
  - Otherwise cnt+1.
- `toggle` defaults to 0 every cycle it is not explicitly set, so it is never high for two consecutive cycles.
- At most one strobe per full press/release cycle. Holding the button produces no repeats.
- DEBOUNCE_CYCLES=1: PRESS_CHK and RELEASE_CHK each last exactly one cycle when the input is stable.

## Timing
- Reset (`rst`=0):
  - Asynchronously clears s1, s2, cnt, `toggle`=0, `pressed`=0, state=RELEASED.
  - Takes effect without a clock edge.
- Reset mid-operation:
  - Any state, including PRESS_CHK or PRESSED, collapses to RELEASED.
  - A button still held after reset deasserts is treated as a new press: full debounce, then a strobe (TOGGLE_ON_RELEASE=0).
- Press latency:
  - `btn` rises meeting setup before edge E0 and then stays high.
  - `toggle` and `pressed` go high after edge E0+DEBOUNCE_CYCLES+2, i.e. the (DEBOUNCE_CYCLES+3)th edge counting E0.
  - Breakdown: 2 sync edges, 1 RELEASED→PRESS_CHK edge, DEBOUNCE_CYCLES PRESS_CHK edges.
- Release latency:
  - Symmetric: `pressed` falls DEBOUNCE_CYCLES+3 edges after a stable `btn` fall.
  - With TOGGLE_ON_RELEASE=1, `toggle` pulses in the same cycle.
- Bounce rejection:
  - Any `btn_s` change during a *_CHK state aborts the check.
  - The counter restarts from 0 on the next entry; stability is never accumulated across aborts.
- `pressed` and the strobe change on the same edge; no combinational path from `btn` to any output.

## Test plan
- Reset: hold `rst`=0 with `btn`=1 for 50 cycles → `toggle`=0 and `pressed`=0 throughout. Assert `rst`=0 mid-simulation between edges → both outputs 0 immediately.
- Clean press, DEBOUNCE_CYCLES=4, TOGGLE_ON_RELEASE=0: `btn` 0→1 before E0, held 30 cycles → `toggle`=1 for exactly one cycle after the 7th edge and `pressed`=1 from that edge; no further strobes.
- Bounce, DEBOUNCE_CYCLES=4: `btn` high 3 cycles, low 2, high 2, low 1, then high 20 → exactly one strobe, 7 edges after the final rise.
- Release glitch: while PRESSED, drop `btn` for 2 cycles → `pressed` stays 1, no strobe. Then drop for 10 cycles → `pressed`=0 after 7 edges, no strobe.
- TOGGLE_ON_RELEASE=1, DEBOUNCE_CYCLES=4: full press/release → no strobe on press; one strobe coincident with `pressed` 1→0.
- Reset in PRESSED with `btn` held: deassert `rst` → outputs 0, then one strobe and `pressed`=1 after 7 edges.

Source files
------------

// File: rtl/button_toggle.sv
// Debounced pushbutton front end: synchronises a raw button, filters bounce
// with a counter-driven FSM and emits one toggle strobe per accepted event.
module button_toggle #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter bit TOGGLE_ON_RELEASE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic toggle,
    output logic pressed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] RELEASED    = 2'd0;
    localparam logic [1:0] PRESS_CHK   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] RELEASE_CHK = 2'd3;

    logic          s1;
    logic          btn_s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // btn is asynchronous to clk; only the second flop is trusted downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= btn;
            btn_s <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RELEASED;
            cnt     <= '0;
            toggle  <= 1'b0;
            pressed <= 1'b0;
        end else begin
            toggle <= 1'b0;
            case (state)
                RELEASED: begin
                    if (btn_s) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= PRESSED;
                        cnt     <= '0;
                        pressed <= 1'b1;
                        toggle  <= !TOGGLE_ON_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                    end
                end
                RELEASE_CHK: begin
                    // A bounce back high is a glitch: pressed never dropped.
                    if (btn_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= RELEASED;
                        cnt     <= '0;
                        pressed <= 1'b0;
                        toggle  <= TOGGLE_ON_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_toggle.sv
// Directed bench for button_toggle: press-strobe, release-strobe and
// single-cycle-debounce instances share one button and reset.
module tb_button_toggle;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic toggle0, pressed0;
    logic toggle1, pressed1;
    logic toggle2, pressed2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    button_toggle #(.DEBOUNCE_CYCLES(4), .TOGGLE_ON_RELEASE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .btn(btn), .toggle(toggle0), .pressed(pressed0));
    button_toggle #(.DEBOUNCE_CYCLES(4), .TOGGLE_ON_RELEASE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .btn(btn), .toggle(toggle1), .pressed(pressed1));
    button_toggle #(.DEBOUNCE_CYCLES(1), .TOGGLE_ON_RELEASE(1'b0)) dut2 (
        .clk(clk), .rst(rst), .btn(btn), .toggle(toggle2), .pressed(pressed2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int n0, n1, n2, f0, f1, f2;
    int p0_at6, p0_at7, p1_at6, p1_at7, t1_at7, p0_min;

    // Run n cycles, counting strobes per instance and the first cycle each appeared.
    task automatic run(input int n);
        n0 = 0; n1 = 0; n2 = 0; f0 = 0; f1 = 0; f2 = 0;
        p0_at6 = -1; p0_at7 = -1; p1_at6 = -1; p1_at7 = -1; t1_at7 = -1; p0_min = 1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (toggle0) begin n0++; if (f0 == 0) f0 = k; end
            if (toggle1) begin n1++; if (f1 == 0) f1 = k; end
            if (toggle2) begin n2++; if (f2 == 0) f2 = k; end
            if (pressed0 == 1'b0) p0_min = 0;
            if (k == 6) begin p0_at6 = int'(pressed0); p1_at6 = int'(pressed1); end
            if (k == 7) begin p0_at7 = int'(pressed0); p1_at7 = int'(pressed1); t1_at7 = int'(toggle1); end
        end
    endtask

    int bounce_n;

    initial begin
        // Reset held with the button high: outputs stay quiet.
        #2 rst = 1'b0;
        btn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (i % 10 == 0) begin
                check("rst_toggle0", int'(toggle0), 0);
                check("rst_pressed0", int'(pressed0), 0);
                check("rst_toggle1", int'(toggle1), 0);
            end
        end
        btn = 1'b0;
        step();
        rst = 1'b1;
        run(10);
        check("idle_strobes", n0 + n1 + n2, 0);

        // Clean press, held 30 cycles.
        btn = 1'b1;
        run(30);
        check("press_count0", n0, 1);
        check("press_first0", f0, 7);
        check("press_pressed0_at6", p0_at6, 0);
        check("press_pressed0_at7", p0_at7, 1);
        check("press_count1", n1, 0);
        check("press_pressed1", int'(pressed1), 1);
        check("press_first_d1", f2, 4);
        check("press_count_d1", n2, 1);

        // Short release glitch: no release accepted.
        btn = 1'b0;
        run(2);
        btn = 1'b1;
        run(20);
        check("glitch_strobes", n0 + n1, 0);
        check("glitch_pressed0", p0_min, 1);

        // Real release: pressed falls after 7 edges; strobe only on dut1.
        btn = 1'b0;
        run(30);
        check("rel_pressed0_at6", p0_at6, 1);
        check("rel_pressed0_at7", p0_at7, 0);
        check("rel_count0", n0, 0);
        check("rel_count1", n1, 1);
        check("rel_first1", f1, 7);
        check("rel_pressed1_at6", p1_at6, 1);
        check("rel_pressed1_at7", p1_at7, 0);
        check("rel_toggle1_at7", t1_at7, 1);

        // Bounce: high 3, low 2, high 2, low 1, then high.
        bounce_n = 0;
        btn = 1'b1; run(3); bounce_n += n0;
        btn = 1'b0; run(2); bounce_n += n0;
        btn = 1'b1; run(2); bounce_n += n0;
        btn = 1'b0; run(1); bounce_n += n0;
        check("bounce_early", bounce_n, 0);
        btn = 1'b1;
        run(25);
        check("bounce_count0", n0, 1);
        check("bounce_first0", f0, 7);
        check("bounce_count1", n1, 0);

        // Asynchronous reset between edges while PRESSED.
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_pressed0", int'(pressed0), 0);
        check("async_pressed1", int'(pressed1), 0);
        check("async_toggle0", int'(toggle0), 0);
        step();
        step();
        rst = 1'b1;
        #1;
        check("post_rst_pressed0", int'(pressed0), 0);
        run(20);
        check("rearm_count0", n0, 1);
        check("rearm_first0", f0, 7);
        check("rearm_pressed0", int'(pressed0), 1);
        check("rearm_count1", n1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
